// File: rtl/next_pc_unit_pkg.sv
// Shared CPU constants: fetch FSM state encoding and PC reset defaults.
package next_pc_unit_pkg;

  // PC and address width used across the CPU datapath
  localparam int PC_WIDTH = 32;

  // Default fetch address after reset (word-aligned)
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Byte distance between sequential instructions
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // RUN: no redirect waiting; PEND: redirect captured while fetch was stalled
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/next_pc_unit_target_sel.sv
// Combinational redirect target selection: jr > jump > branch.
module pc_target_sel
  import next_pc_unit_pkg::*;
(
  input  logic [31:0] base_pc_i,
  input  logic        branch_i,
  input  logic [31:0] branch_offset_i,
  input  logic        jump_i,
  input  logic [27:0] jump_target_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  output logic        req_o,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  // Pick the highest-priority request and form its target address
  always_comb begin
    req_o        = jr_i | jump_i | branch_i;
    target_o     = base_pc_i + {branch_offset_i[29:0], 2'b00};
    misaligned_o = 1'b0;
    if (jr_i) begin
      target_o     = {jr_addr_i[31:2], 2'b00};
      misaligned_o = (jr_addr_i[1:0] != 2'b00);
    end else if (jump_i) begin
      target_o = {base_pc_i[31:28], jump_target_i};
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register with stall handling and a one-deep pending redirect.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          WIDTH    = PC_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic [WIDTH-1:0] base_pc_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] branch_offset_i,
  input  logic             jump_i,
  input  logic [27:0]      jump_target_i,
  input  logic             jr_i,
  input  logic [WIDTH-1:0] jr_addr_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             redirect_o,
  output logic             misaligned_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic         pend_mis_q, pend_mis_d;
  logic         redirect_q, redirect_d;
  logic         mis_q, mis_d;

  logic         sel_req;
  logic [31:0]  sel_target;
  logic         sel_mis;

  pc_target_sel u_target_sel (
    .base_pc_i       (base_pc_i),
    .branch_i        (branch_i),
    .branch_offset_i (branch_offset_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .jr_i            (jr_i),
    .jr_addr_i       (jr_addr_i),
    .req_o           (sel_req),
    .target_o        (sel_target),
    .misaligned_o    (sel_mis)
  );

  // Next-state, next-PC and pending-redirect decisions for RUN/PEND
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_mis_d    = pend_mis_q;
    redirect_d    = 1'b0;
    mis_d         = 1'b0;
    unique case (state_q)
      RUN: begin
        if (sel_req) begin
          if (stall_i) begin
            pend_target_d = sel_target;
            pend_mis_d    = sel_mis;
            state_d       = PEND;
          end else begin
            pc_d       = sel_target;
            redirect_d = 1'b1;
            mis_d      = sel_mis;
          end
        end else if (!stall_i) begin
          pc_d = pc_q + INSTR_BYTES;
        end
      end
      PEND: begin
        if (stall_i) begin
          if (sel_req) begin
            pend_target_d = sel_target;
            pend_mis_d    = sel_mis;
          end
        end else begin
          if (sel_req) begin
            pc_d  = sel_target;
            mis_d = sel_mis;
          end else begin
            pc_d  = pend_target_q;
            mis_d = pend_mis_q;
          end
          redirect_d    = 1'b1;
          pend_target_d = 32'h0;
          pend_mis_d    = 1'b0;
          state_d       = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers; reset overrides stall and any pending or incoming redirect
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'h0;
      pend_mis_q    <= 1'b0;
      redirect_q    <= 1'b0;
      mis_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pend_mis_q    <= pend_mis_d;
      redirect_q    <= redirect_d;
      mis_q         <= mis_d;
    end
  end

  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_q + INSTR_BYTES;
  assign redirect_o   = redirect_q;
  assign misaligned_o = mis_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Table-driven directed bench for next_pc_unit.
module tb_next_pc_unit;

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic [31:0] base;
    logic        branch;
    logic [31:0] offset;
    logic        jump;
    logic [27:0] jtarget;
    logic        jr;
    logic [31:0] jraddr;
    logic [31:0] expPc;
    logic        expRedirect;
    logic        expMis;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic [31:0] base_pc_i = '0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_offset_i = '0;
  logic        jump_i = 1'b0;
  logic [27:0] jump_target_i = '0;
  logic        jr_i = 1'b0;
  logic [31:0] jr_addr_i = '0;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        redirect_o;
  logic        misaligned_o;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  next_pc_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .base_pc_i       (base_pc_i),
    .branch_i        (branch_i),
    .branch_offset_i (branch_offset_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .jr_i            (jr_i),
    .jr_addr_i       (jr_addr_i),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .redirect_o      (redirect_o),
    .misaligned_o    (misaligned_o)
  );

  // Free-running clock, 10 time units per period
  always #5 clk_i = ~clk_i;

  task automatic addVec(input string name, input logic rst, input logic stall,
                        input logic [31:0] base, input logic branch, input logic [31:0] offset,
                        input logic jump, input logic [27:0] jtarget,
                        input logic jr, input logic [31:0] jraddr,
                        input logic [31:0] expPc, input logic expRedirect, input logic expMis);
    vec_t v;
    v.name = name; v.rst = rst; v.stall = stall; v.base = base; v.branch = branch;
    v.offset = offset; v.jump = jump; v.jtarget = jtarget; v.jr = jr; v.jraddr = jraddr;
    v.expPc = expPc; v.expRedirect = expRedirect; v.expMis = expMis;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk_i);
    rst_i           = v.rst;
    stall_i         = v.stall;
    base_pc_i       = v.base;
    branch_i        = v.branch;
    branch_offset_i = v.offset;
    jump_i          = v.jump;
    jump_target_i   = v.jtarget;
    jr_i            = v.jr;
    jr_addr_i       = v.jraddr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkVec(input vec_t v);
    checkOutput({v.name, ".pc"}, pc_o, v.expPc);
    checkOutput({v.name, ".pc_plus4"}, pc_plus4_o, v.expPc + 32'd4);
    checkOutput({v.name, ".redirect"}, {31'b0, redirect_o}, {31'b0, v.expRedirect});
    checkOutput({v.name, ".misaligned"}, {31'b0, misaligned_o}, {31'b0, v.expMis});
  endtask

  initial begin
    //      name          rst stall base          br off           jmp jtarget       jr jraddr        expPc         red mis
    addVec("reset",       1, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0000, 0, 0);
    addVec("seq1",        0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0004, 0, 0);
    addVec("seq2",        0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0008, 0, 0);
    addVec("seq3",        0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_000C, 0, 0);
    addVec("branchBack",  0, 0, 32'h40,        1, 32'hFFFF_FFFE,0, 28'h0,        0, 32'h0,        32'h0000_0038, 1, 0);
    addVec("afterBr",     0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_003C, 0, 0);
    addVec("jumpWins",    0, 0, 32'h9000_0010, 1, 32'h10,       1, 28'h0ABC_DE0, 0, 32'h0,        32'h90AB_CDE0, 1, 0);
    addVec("afterJmp",    0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h90AB_CDE4, 0, 0);
    addVec("jrStall1",    0, 1, 32'h0,         0, 32'h0,        0, 28'h0,        1, 32'h0000_1003,32'h90AB_CDE4, 0, 0);
    addVec("jrStall2",    0, 1, 32'h0,         0, 32'h0,        0, 28'h0,        1, 32'h0000_1003,32'h90AB_CDE4, 0, 0);
    addVec("jrStall3",    0, 1, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h90AB_CDE4, 0, 0);
    addVec("jrRelease",   0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_1000, 1, 1);
    addVec("afterJr",     0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_1004, 0, 0);
    addVec("jrTop",       0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        1, 32'hFFFF_FFFC,32'hFFFF_FFFC, 1, 0);
    addVec("wrap",        0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0000, 0, 0);
    addVec("seq4",        0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0004, 0, 0);
    addVec("pendJr",      0, 1, 32'h0,         0, 32'h0,        0, 28'h0,        1, 32'h0000_2000,32'h0000_0004, 0, 0);
    addVec("rstInPend",   1, 1, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0000, 0, 0);
    addVec("noStalePend", 0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0004, 0, 0);
    addVec("pendBranch",  0, 1, 32'h100,       1, 32'h1,        0, 28'h0,        0, 32'h0,        32'h0000_0004, 0, 0);
    addVec("pendOverwr",  0, 1, 32'h0,         0, 32'h0,        1, 28'h000_0200, 0, 32'h0,        32'h0000_0004, 0, 0);
    addVec("pendRelease", 0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0200, 1, 0);
    addVec("pendMisJr",   0, 1, 32'h0,         0, 32'h0,        0, 28'h0,        1, 32'h0000_3001,32'h0000_0200, 0, 0);
    addVec("newReqWins",  0, 0, 32'h10,        1, 32'h4,        0, 28'h0,        0, 32'h0,        32'h0000_0020, 1, 0);
    addVec("backToBack",  0, 0, 32'h20,        1, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0020, 1, 0);
    addVec("afterB2B",    0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0024, 0, 0);
    addVec("runStall",    0, 1, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0024, 0, 0);
    addVec("runResume",   0, 0, 32'h0,         0, 32'h0,        0, 28'h0,        0, 32'h0,        32'h0000_0028, 0, 0);
    addVec("rstVsBranch", 1, 0, 32'h40,        1, 32'h8,        0, 28'h0,        0, 32'h0,        32'h0000_0000, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkVec(vecs[i]);
    end

    // Hand-written: long stall with a pending misaligned JR, then redirect pulse lasts one cycle
    begin
      vec_t v;
      v = vecs[1];
      v.name = "longPend"; v.stall = 1'b1; v.jr = 1'b1; v.jraddr = 32'h0000_5002;
      v.expPc = 32'h0000_0000; v.expRedirect = 1'b0; v.expMis = 1'b0;
      applyStimulus(v);
      checkVec(v);
      v.jr = 1'b0;
      for (int k = 0; k < 5; k++) begin
        applyStimulus(v);
        checkVec(v);
      end
      v.name = "longRel"; v.stall = 1'b0;
      v.expPc = 32'h0000_5000; v.expRedirect = 1'b1; v.expMis = 1'b1;
      applyStimulus(v);
      checkVec(v);
      v.name = "pulseEnd";
      v.expPc = 32'h0000_5004; v.expRedirect = 1'b0; v.expMis = 1'b0;
      applyStimulus(v);
      checkVec(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset (word-aligned).
REQ-002 SHALL have parameter WIDTH, default 32: PC/address width (fixed at 32 for this project).
REQ-003 Clocking SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 stall_i  input  1  fetch hold; PC must not advance while high.
REQ-007 base_pc_i  input  32  PC+4 of the redirecting instruction; base for branch/jump.
REQ-008 branch_i  input  1  taken-branch request.
REQ-009 branch_offset_i  input  32  sign-extended word offset (unshifted).
REQ-010 jump_i  input  1  J/JAL request.
REQ-011 jump_target_i  input  28  shifted jump field (instr[25:0] followed by 2'b00).
REQ-012 jr_i  input  1  register-jump request.
REQ-013 jr_addr_i  input  32  register-jump target.
REQ-014 pc_o  output  32  current fetch PC (registered).
REQ-015 pc_plus4_o  output  32  pc_o + 4, modulo 2^32.
REQ-016 redirect_o  output  1  high exactly in the first cycle pc_o shows a redirect target; decode-flush strobe.
REQ-017 misaligned_o  output  1  high together with redirect_o when the applied JR target had nonzero bits [1:0].

Function
REQ-018 Target selection SHALL use fixed priority jr_i > jump_i > branch_i; a redirect request exists when any of the three is high.
REQ-019 Jump target SHALL be {base_pc_i[31:28], jump_target_i}.
REQ-020 Branch target SHALL be base_pc_i + (branch_offset_i << 2), truncated to 32 bits (wrap, no overflow flag).
REQ-021 JR target SHALL be {jr_addr_i[31:2], 2'b00}; the misalignment flag SHALL be captured with the target.
REQ-022 FSM SHALL have two states: RUN (no pending redirect) and PEND (redirect captured during stall).
REQ-023 RUN, no request, stall_i=0: pc_o <= pc_o + 4; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 RUN, no request, stall_i=1: pc_o holds; state stays RUN.
REQ-025 RUN, request, stall_i=0: pc_o <= selected target next cycle; redirect_o=1 in that cycle; stay RUN.
REQ-026 RUN, request, stall_i=1: pc_o holds; target and misaligned flag latch into pending register; go PEND.
REQ-027 PEND, stall_i=1: pc_o holds; a new request overwrites the pending target/flag; otherwise the pending value is kept.
REQ-028 PEND, stall_i=0: pc_o <= new request's target if a request is present, else pending target; redirect_o=1 next cycle; go RUN.
REQ-029 redirect_o and misaligned_o SHALL be registered single-cycle pulses; they are never high in consecutive cycles unless consecutive redirects are applied.
REQ-030 Fetch latency: a redirect applied at edge N is visible on pc_o after edge N; no combinational path from request inputs to pc_o.

Reset
REQ-031 rst_i=1 at a rising edge SHALL set pc_o=RESET_PC, state=RUN, pending register=0, redirect_o=0, misaligned_o=0.
REQ-032 Reset SHALL override stall and any pending or simultaneous redirect, including reset asserted in PEND.

Structure
REQ-033 State encoding (RUN/PEND) and RESET_PC default SHALL live in a shared package with the other CPU constants.
REQ-034 Target arithmetic SHALL be one combinational sub-module, pc_target_sel, that feeds the registered FSM/PC logic; the shifted jump field is consumed as provided.

Verification
REQ-035 Reset then 3 unstalled cycles -> pc_o = 0x0, 0x4, 0x8, 0xC; redirect_o = 0 throughout.
REQ-036 base_pc_i=0x0000_0040, branch_offset_i=0xFFFF_FFFE, branch_i=1, no stall -> next pc_o=0x0000_0038, redirect_o=1 for 1 cycle.
REQ-037 base_pc_i=0x9000_0010, jump_target_i=0x0ABC_DE0, jump_i=1 and branch_i=1 together -> pc_o=0x90AB_CDE0 (jump wins).
REQ-038 jr_i=1, jr_addr_i=0x0000_1003, stall_i=1 for 3 cycles then 0 -> pc_o holds 3 cycles, then 0x0000_1000 with redirect_o=1 and misaligned_o=1.
REQ-039 PC forced to 0xFFFF_FFFC via JR, no stall -> next pc_o=0x0000_0000; pc_plus4_o=0x0000_0000 while pc_o=0xFFFF_FFFC.
REQ-040 In PEND, rst_i=1 for one cycle -> pc_o=RESET_PC, pending target discarded, no redirect_o pulse after stall release.
